// File: rtl/line_fill_memory.sv
// line_fill_memory
// ----------------
// Main-memory responder behind the L1 cache controller. Serves whole-line
// requests (4 x 32-bit words = 128-bit line). Only one request is in flight
// at a time. A read returns the line LAT cycles after the request is accepted.
// A write-back commits the line on that same cycle and echoes the data back.
//
// Ports
//   clk         clock; all state changes on the rising edge
//   rst         asynchronous, active-high reset
//   req_valid   request present
//   req_ready   responder idle and able to accept a request
//   req_we      1 = line write, 0 = line read
//   req_addr    word address; bits [1:0] select a word within the line and are ignored
//   req_wdata   write line, [127:96] = word offset 0 ... [31:0] = word offset 3
//   resp_valid  response line available
//   resp_ready  requester takes the response
//   resp_rdata  response line, same word order as req_wdata
//
// Power-up contents: the word at address a reads back as a, zero-extended.
// Configured FPGA block RAM comes up all-zero. The array therefore stores each
// line XORed with its power-up pattern. A zero cell decodes to the required
// initial value, so no init file or init sweep is needed.

module line_fill_memory #(
    parameter int ADDR_W = 12,
    parameter int LAT    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [127:0]      req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [127:0]      resp_rdata
);

    localparam int LINE_W = ADDR_W - 2;
    localparam int DEPTH  = 1 << LINE_W;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t              state_reg;
    state_t              state_next;
    logic [3:0]          cnt_reg;
    logic [LINE_W-1:0]   line_reg;
    logic                we_reg;
    logic [127:0]        wdata_reg;
    logic [127:0]        line_pat;
    logic                done;

    logic [127:0]        mem [DEPTH];

    // The word offset inside a line is deliberately unused.
    logic                unused_offset;
    assign unused_offset = ^req_addr[1:0];

    // Power-up pattern of the captured line: word gi holds {line, gi}.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_pat
            assign line_pat[127-32*gi -: 32] = 32'({line_reg, 2'(gi)});
        end
    endgenerate

    // Completion edge: the counter steps from 1 to 0 while in WAIT.
    assign done = (state_reg == WAIT) && (cnt_reg == 4'd1);

    assign req_ready  = (state_reg == IDLE);
    assign resp_valid = (state_reg == RESP);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (req_valid)  state_next = WAIT;
            WAIT:    if (done)       state_next = RESP;
            RESP:    if (resp_ready) state_next = IDLE;
            default:                 state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= IDLE;
            cnt_reg    <= 4'd0;
            line_reg   <= '0;
            we_reg     <= 1'b0;
            wdata_reg  <= '0;
            resp_rdata <= '0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    if (req_valid) begin
                        line_reg  <= req_addr[ADDR_W-1:2];
                        we_reg    <= req_we;
                        wdata_reg <= req_wdata;
                        cnt_reg   <= 4'(LAT);
                    end
                end
                WAIT: begin
                    cnt_reg <= cnt_reg - 4'd1;
                    if (done) begin
                        resp_rdata <= we_reg ? wdata_reg : (mem[line_reg] ^ line_pat);
                    end
                end
                default: ;
            endcase
        end
    end

    // Line storage, never reset. Reset forces state_reg to IDLE
    // asynchronously, which drops done. A write that is still pending when
    // reset arrives therefore never commits.
    always_ff @(posedge clk) begin
        if (done && we_reg) begin
            mem[line_reg] <= wdata_reg ^ line_pat;
        end
    end

endmodule

// File: tb/tb_line_fill_memory.sv
module tb_line_fill_memory;

    localparam int ADDR_W = 12;
    localparam int LAT    = 4;
    localparam int PERIOD = 10;

    logic          clk        = 1'b0;
    logic          clk_en     = 1'b0;
    logic          rst        = 1'b0;
    logic          req_valid  = 1'b0;
    logic          req_ready;
    logic          req_we     = 1'b0;
    logic [11:0]   req_addr   = '0;
    logic [127:0]  req_wdata  = '0;
    logic          resp_valid;
    logic          resp_ready = 1'b0;
    logic [127:0]  resp_rdata;

    int checks = 0;
    int errors = 0;
    int rr_mode = 1;   // 0 random, 1 always ready, 2 stalled

    typedef struct {
        logic         we;
        int           line;
        logic [127:0] data;
        time          acc_t;
    } exp_t;

    exp_t         sb[$];
    logic [127:0] ref_lines [int];

    line_fill_memory #(.ADDR_W(ADDR_W), .LAT(LAT)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata)
    );

    always #(PERIOD/2) if (clk_en) clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: untouched lines hold their addresses; written lines are
    // kept in an associative array.
    function automatic logic [127:0] default_line(input int line);
        logic [127:0] v;
        v = '0;
        for (int k = 0; k < 4; k++) v[127-32*k -: 32] = 32'(line * 4 + k);
        return v;
    endfunction

    function automatic logic [127:0] ref_read(input int line);
        if (ref_lines.exists(line)) return ref_lines[line];
        return default_line(line);
    endfunction

    // Response-side backpressure, changed away from the sampling edge.
    always begin
        @(posedge clk);
        #2;
        case (rr_mode)
            0:       resp_ready = ($urandom_range(0, 2) != 0);
            1:       resp_ready = 1'b1;
            default: resp_ready = 1'b0;
        endcase
    end

    // Monitor: latency, stability, data and post-retire state.
    logic         prev_valid   = 1'b0;
    logic [127:0] prev_data    = '0;
    logic         retire_check = 1'b0;
    time          last_retire_t = 0;

    always @(negedge clk) begin
        exp_t e;
        if (retire_check) begin
            check("ready_after_retire", 128'(req_ready), 128'(1));
            check("valid_after_retire", 128'(resp_valid), 128'(0));
            retire_check = 1'b0;
        end
        if (resp_valid) begin
            check("req_ready_low_in_resp", 128'(req_ready), 128'(0));
            if (!prev_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_resp", 128'(1), 128'(0));
                end else begin
                    check("latency", 128'($time - sb[0].acc_t), 128'(LAT * PERIOD + PERIOD / 2));
                    if (sb[0].we) ref_lines[sb[0].line] = sb[0].data;
                end
            end else begin
                check("rdata_stable", resp_rdata, prev_data);
            end
            if (resp_ready && sb.size() != 0) begin
                e = sb.pop_front();
                check("resp_data", resp_rdata, e.data);
                $display("resp %s line %03h data %h", e.we ? "wr" : "rd", e.line, resp_rdata);
                retire_check  = 1'b1;
                last_retire_t = $time;
            end
        end
        prev_valid = resp_valid;
        prev_data  = resp_rdata;
    end

    task automatic do_req(input logic we, input logic [11:0] addr, input logic [127:0] wd,
                          output time acc);
        exp_t e;
        int   n;
        n = 0;
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wd;
        while (!req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            check("accept_timeout", 128'(0), 128'(1));
            req_valid = 1'b0;
            acc = 0;
            return;
        end
        @(posedge clk);
        acc     = $time;
        e.we    = we;
        e.line  = int'(addr[11:2]);
        e.data  = we ? wd : ref_read(int'(addr[11:2]));
        e.acc_t = $time;
        sb.push_back(e);
        #1;
        req_valid = 1'b0;
        req_we    = 1'($urandom);
        req_addr  = 12'($urandom);
        req_wdata = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((sb.size() != 0 || !req_ready) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) check("idle_timeout", 128'(0), 128'(1));
    endtask

    initial begin
        time          acc;
        time          acc2;
        int           n;
        logic [127:0] wd;
        logic [9:0]   line;

        // Reset with the clock stopped: outputs must settle immediately.
        #3 rst = 1'b1;
        #1;
        check("rst_req_ready", 128'(req_ready), 128'(1));
        check("rst_resp_valid", 128'(resp_valid), 128'(0));
        check("rst_resp_rdata", resp_rdata, 128'h0);
        #5 clk_en = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Directed reads, offset handling, write/echo/read-back.
        rr_mode = 1;
        do_req(1'b0, 12'h014, '0, acc);
        wait_idle();
        do_req(1'b0, 12'h017, '0, acc);
        do_req(1'b1, 12'h100, {32'hDEADBEEF, 32'h1, 32'h2, 32'h3}, acc);
        do_req(1'b0, 12'h102, '0, acc);
        do_req(1'b0, 12'h104, '0, acc);
        wait_idle();

        // Backpressure with a second request waiting.
        rr_mode = 2;
        repeat (2) @(negedge clk);
        do_req(1'b0, 12'h020, '0, acc);
        n = 0;
        while (!resp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("bp_valid_seen", 128'(resp_valid), 128'(1));
        fork
            do_req(1'b0, 12'h040, '0, acc2);
            begin
                repeat (10) begin
                    @(negedge clk);
                    check("bp_ready_low", 128'(req_ready), 128'(0));
                    check("bp_valid_held", 128'(resp_valid), 128'(1));
                end
                rr_mode = 1;
            end
        join
        check("bp_accept_after_retire", 128'(acc2 > last_retire_t + PERIOD / 2), 128'(1));
        wait_idle();

        // Reset two cycles into a pending write: nothing commits.
        do_req(1'b1, 12'h200, {4{32'hA5A5_0000}}, acc);
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_req_ready", 128'(req_ready), 128'(1));
        check("midrst_resp_valid", 128'(resp_valid), 128'(0));
        check("midrst_resp_rdata", resp_rdata, 128'h0);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        do_req(1'b0, 12'h200, '0, acc);
        wait_idle();

        // Random traffic over a small window spanning the address wrap.
        rr_mode = 0;
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 3) == 0) line = 10'($urandom);
            else                           line = 10'(1020 + $urandom_range(0, 7));
            wd = {$urandom, $urandom, $urandom, $urandom};
            do_req(($urandom_range(0, 2) == 0), {line, 2'($urandom)}, wd, acc);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        rr_mode = 1;
        wait_idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/line_fill_memory.md
Name: line_fill_memory

Overview:
- Main-memory responder for the L1 line-fill interface; sits behind the L1 cache controller.
- Serves whole-line requests: 4 words × 32 bits = 128-bit line, word-addressed by a 12-bit address.
- Reads return a line after a fixed, parameterised latency; write-backs commit a whole line.
- Single outstanding request; valid/ready handshake on both the request and the response channel.

Parameters:
- ADDR_W, 12, word-address width; line index = addr[ADDR_W-1:2]; memory depth = 2^(ADDR_W-2) lines.
- LAT, 4, cycles from request acceptance to resp_valid; legal range 1..15.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request.
- req_we  input  1  1 = line write, 0 = line read.
- req_addr  input  ADDR_W  word address; bits [1:0] ignored.
- req_wdata  input  128  write line; [127:96] = word offset 0 … [31:0] = word offset 3.
- resp_valid  output  1  response line available.
- resp_ready  input  1  requester takes the response.
- resp_rdata  output  128  line data; same word order as req_wdata.

Behaviour:
- Reset (async, immediate): state = IDLE, req_ready = 1, resp_valid = 0, resp_rdata = 0, latency counter = 0.
  - Memory array is not reset.
  - At time zero the array is initialised so that word at address a holds a, zero-extended to 32 bits.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready = 1.
  - On a rising edge with req_valid = 1, capture line index, req_we and req_wdata; load counter with LAT; go to WAIT.
- WAIT:
  - req_ready = 0; counter decrements each edge.
  - On the edge where the counter goes 1 → 0:
    - Read: resp_rdata ← mem[line].
    - Write: mem[line] ← captured wdata, and resp_rdata ← captured wdata (echo).
  - resp_valid = 1 from that edge; go to RESP.
- RESP:
  - resp_valid = 1, req_ready = 0; resp_rdata held stable.
  - On an edge with resp_ready = 1: resp_valid ← 0; go to IDLE.
  - The edge that retires a response never accepts a new request.
- Latency:
  - resp_valid is visible exactly LAT edges after the acceptance edge.
  - Minimum request-to-request spacing is LAT + 2 cycles when resp_ready is held at 1.
- resp_rdata:
  - Holds its last value after retirement.
  - Changes only on the completion edge in WAIT, or on reset.
- Ignored inputs:
  - req_valid, req_we, req_addr and req_wdata are ignored outside IDLE.
  - A requester that raises req_valid during WAIT or RESP is not lost: it keeps req_valid high until req_ready = 1.
- Offset: req_addr[1:0] is ignored; any address within a line returns or writes the full line.
- Wrap: the line index covers the whole address space; there is no out-of-range condition.
- Reset mid-operation:
  - A pending write that has not reached its completion edge is dropped; memory is unchanged.
  - A pending read is discarded.
- Reset on the completion edge: reset dominates; no write commits.
- resp_ready while not in RESP: ignored.

Test Plan:
1. Reset: assert rst mid-cycle, clock stopped → req_ready = 1, resp_valid = 0, resp_rdata = 128'h0 immediately.
2. Read latency (LAT = 4): read at addr 12'h014, resp_ready = 1:
   - resp_valid rises exactly 4 edges after acceptance.
   - resp_rdata = {32'h14, 32'h15, 32'h16, 32'h17}.
   - req_ready is back to 1 one cycle after the response handshake.
3. Offset ignored: read at addr 12'h017 → resp_rdata = {32'h14, 32'h15, 32'h16, 32'h17}.
4. Write then read: write 12'h100 with {32'hDEADBEEF, 32'h1, 32'h2, 32'h3}:
   - The write echoes that data.
   - A following read at 12'h102 returns the same line.
   - A read at 12'h104 still returns {32'h104, 32'h105, 32'h106, 32'h107}.
5. Backpressure: hold resp_ready = 0 for 10 cycles after resp_valid, with req_valid = 1 and a different address:
   - resp_valid and resp_rdata stay stable; req_ready = 0 throughout.
   - The second request is accepted only in IDLE after the handshake.
6. Reset during write: issue a write to 12'h200 and assert rst 2 cycles after acceptance:
   - Outputs return to reset values.
   - A subsequent read at 12'h200 returns {32'h200, 32'h201, 32'h202, 32'h203}.
